mux_arb: RTL and testbench

Parametrised N-way, WIDTH-bit selector with a registered output and valid/ready handshakes. It generalises the fixed 8:1 32-bit combinational mux into an arbitrating mux, so several producers can share one downstream consumer. Typical producers are pipeline result sources and write-back requesters; typical consumers are write-back ports and bus masters. Input arbitration is round-robin or fixed-priority, can be overridden by a forced select, and the output stage supports stall and flush.

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_pick.sv | 27 ++
 rtl/mux_arb.sv | 65 ++++++
 tb/tb_mux_arb.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and elaboration-time helpers for the arbitrating mux.
package mux_pkg;
   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set req bit searching start, start+1, ... with wrap at N.
module rr_pick #(
   parameter int N    = 8,
   parameter int SELW = 3
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] start,
   output logic [SELW-1:0] gnt_idx,
   output logic            gnt_any
);
   int idx;

   // Walk offsets from farthest to nearest so the nearest requester is written last.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(start) + k;
         if (idx >= N) idx = idx - N;
         if (req[idx]) begin
            gnt_idx = SELW'(idx);
            gnt_any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mux_arb.sv
// N-way arbitrating mux with a registered output stage, stall, flush and forced select.
module mux_arb
   import mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N     = 8,
   parameter int MODE  = MODE_RR,
   localparam int SELW = (clog2(N) > 1) ? clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 force_en,
   input  logic [SELW-1:0]      force_sel,
   input  logic                 flush,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_sel,
   output logic                 out_valid,
   input  logic                 out_ready
);
   logic [N-1:0][WIDTH-1:0] chans;
   logic [SELW-1:0]         ptr, start, pick_idx, win_idx;
   logic                    pick_any, win_any, load_en, fsel_ok;

   assign chans   = in_data;
   assign load_en = !rst && (!out_valid || out_ready) && !flush;
   // Range test first so an out-of-range force_sel never reaches the in_valid index.
   assign fsel_ok = (32'(force_sel) < 32'(N)) && in_valid[force_sel];
   assign start   = (MODE == MODE_FIXED) ? '0 : ptr;

   rr_pick #(.N(N), .SELW(SELW)) u_pick (
      .req     (in_valid),
      .start   (start),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

   always_comb begin
      win_idx  = force_en ? force_sel : pick_idx;
      win_any  = force_en ? fsel_ok : pick_any;
      in_ready = '0;
      if (load_en && win_any) in_ready[win_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load_en) begin
         out_valid <= win_any;
         if (win_any) begin
            out_data <= chans[win_idx];
            out_sel  <= win_idx;
            if (MODE == MODE_RR && !force_en)
               ptr <= (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench: three mux_arb flavours (8-way RR, 5-way RR, 8-way fixed) share one stimulus stream.
module tb_mux_arb;
   typedef struct {
      int          sel;
      logic [31:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [255:0] in_data = '0;
   logic [7:0]   in_valid = '0;
   logic         force_en = 1'b0;
   logic [2:0]   force_sel = '0;
   logic         flush = 1'b0;
   logic         out_ready = 1'b0;

   logic [7:0]   rdy_a, rdy_c;
   logic [4:0]   rdy_b;
   logic [31:0]  od[3];
   logic [2:0]   os[3];
   logic         ov[3];

   int   cmp = 0, err = 0;
   int   mptr[3];
   exp_t eq[3][$];
   bit   prev_rst = 1'b0, mon_on = 1'b0;
   int   dmode = 0;

   always #5 clk = ~clk;

   mux_arb #(.WIDTH(32), .N(8), .MODE(0)) u_rr8 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
      .force_en(force_en), .force_sel(force_sel), .flush(flush),
      .out_data(od[0]), .out_sel(os[0]), .out_valid(ov[0]), .out_ready(out_ready));

   mux_arb #(.WIDTH(32), .N(5), .MODE(0)) u_rr5 (
      .clk(clk), .rst(rst), .in_data(in_data[159:0]), .in_valid(in_valid[4:0]), .in_ready(rdy_b),
      .force_en(force_en), .force_sel(force_sel), .flush(flush),
      .out_data(od[1]), .out_sel(os[1]), .out_valid(ov[1]), .out_ready(out_ready));

   mux_arb #(.WIDTH(32), .N(8), .MODE(1)) u_fix8 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_c),
      .force_en(force_en), .force_sel(force_sel), .flush(flush),
      .out_data(od[2]), .out_sel(os[2]), .out_valid(ov[2]), .out_ready(out_ready));

   function automatic int nn(input int k);
      return (k == 1) ? 5 : 8;
   endfunction

   function automatic logic [7:0] get_rdy(input int k);
      if (k == 0) return rdy_a;
      if (k == 1) return {3'b000, rdy_b};
      return rdy_c;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference winner straight from the selection rules.
   function automatic int pick(input int k, input logic [7:0] v, input bit fe, input int fs);
      int n;
      n = nn(k);
      if (fe) return (fs < n && v[fs]) ? fs : -1;
      if (k == 2) begin
         for (int i = 0; i < n; i++) if (v[i]) return i;
         return -1;
      end
      for (int j = 0; j < n; j++)
         if (v[(mptr[k] + j) % n]) return (mptr[k] + j) % n;
      return -1;
   endfunction

   // Monitor: whatever the output register shows must match the scoreboard head.
   always @(negedge clk) begin
      if (mon_on) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(eq[k].size() != 0));
            if (eq[k].size() != 0 && ov[k] === 1'b1) begin
               chk($sformatf("out_sel[%0d]", k), 32'(os[k]), 32'(eq[k][0].sel));
               chk($sformatf("out_data[%0d]", k), od[k], eq[k][0].data);
            end
            if (prev_rst) begin
               chk($sformatf("rst_data[%0d]", k), od[k], 32'h0);
               chk($sformatf("rst_sel[%0d]", k), 32'(os[k]), 32'h0);
            end
         end
      end
   end

   task automatic cyc(input bit r, input logic [7:0] v, input bit fe, input int fs,
                      input bit fl, input bit ordy);
      @(negedge clk);
      #1;
      rst = r; in_valid = v; force_en = fe; force_sel = fs[2:0]; flush = fl; out_ready = ordy;
      for (int c = 0; c < 8; c++)
         in_data[c*32 +: 32] = (dmode == 1) ? 32'hA0 + c : (dmode == 2) ? 32'hDEADBEEF : $urandom;
      #1;
      for (int k = 0; k < 3; k++) begin
         int         w;
         logic [7:0] er;
         bit         load;
         er   = '0;
         w    = -1;
         load = !r && (eq[k].size() == 0 || ordy) && !fl;
         if (load) w = pick(k, v, fe, fs);
         if (w >= 0) er[w] = 1'b1;
         chk($sformatf("in_ready[%0d]", k), 32'(get_rdy(k)), 32'(er));
         if (r) begin
            eq[k].delete();
            mptr[k] = 0;
         end else if (fl) begin
            eq[k].delete();
         end else if (load) begin
            eq[k].delete();
            if (w >= 0) begin
               eq[k].push_back('{w, in_data[w*32 +: 32]});
               if (k != 2 && !fe) mptr[k] = (w + 1) % nn(k);
            end
         end
      end
      prev_rst = r;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) mptr[k] = 0;
      // Reset with every channel requesting.
      cyc(1, 8'hFF, 0, 0, 0, 1);
      cyc(1, 8'hFF, 0, 0, 0, 1);
      mon_on = 1'b1;
      // Round-robin sweep with recognisable data.
      dmode = 1;
      for (int i = 0; i < 10; i++) cyc(0, 8'hFF, 0, 0, 0, 1);
      // Fixed priority, then forced grants (in and out of range).
      dmode = 0;
      for (int i = 0; i < 3; i++) cyc(0, 8'h0C, 0, 0, 0, 1);
      cyc(0, 8'h0C, 1, 3, 0, 1);
      cyc(0, 8'h0C, 1, 3, 0, 1);
      cyc(0, 8'h0C, 1, 5, 0, 1);
      // Drive the 5-way pointer to 4, then request only channels 0 and 1.
      cyc(0, 8'h08, 0, 0, 0, 1);
      cyc(0, 8'h03, 0, 0, 0, 1);
      cyc(0, 8'h03, 0, 0, 0, 1);
      cyc(0, 8'h03, 0, 0, 0, 1);
      // Stall holding a known word.
      dmode = 2;
      cyc(0, 8'hFF, 0, 0, 0, 1);
      dmode = 0;
      for (int i = 0; i < 4; i++) cyc(0, 8'hFF, 0, 0, 0, 0);
      cyc(0, 8'hFF, 0, 0, 0, 1);
      cyc(0, 8'hFF, 0, 0, 0, 1);
      // Flush while stalled, then a single request on channel 6.
      cyc(0, 8'hFF, 0, 0, 0, 0);
      cyc(0, 8'hFF, 0, 0, 1, 0);
      cyc(0, 8'h40, 0, 0, 0, 1);
      cyc(0, 8'h00, 0, 0, 0, 1);
      // Random traffic.
      for (int i = 0; i < 400; i++)
         cyc(($urandom_range(0, 49) == 0), 8'($urandom), ($urandom_range(0, 6) == 0),
             int'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
      cyc(0, 8'h00, 0, 0, 0, 1);
      @(negedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end
endmodule
